// File: rtl/bp_common_pkg.sv
// ----------------------------------------------------------------------------
// bp_common_pkg
//   Shared Sv39 definitions for the TLB / page-table-walker slice:
//   - address widths for the processor configuration (39-bit VA, 56-bit PA)
//   - bp_ptw_state_e    : walker FSM states
//   - bp_sv39_pte_s     : raw 64-bit Sv39 page-table entry
//   - bp_pte_entry_leaf_s : leaf entry written into the TLB {ptag, d,a,u,x,w,r}
//   - sv39_level_mask() : mask of the PPN bits covered by a superpage at a level
// ----------------------------------------------------------------------------
package bp_common_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int paddr_width_gp = 56;
    localparam int vtag_width_gp  = vaddr_width_gp - 12;
    localparam int ptag_width_gp  = paddr_width_gp - 12;

    localparam int sv39_levels_gp            = 3;
    localparam int sv39_vpn_width_gp         = 9;
    localparam int sv39_pte_size_in_bytes_gp = 8;
    localparam int sv39_pte_offset_width_gp  = $clog2(sv39_pte_size_in_bytes_gp);
    localparam int sv39_level_width_gp       = $clog2(sv39_levels_gp);

    typedef enum logic [2:0] {
        e_idle,
        e_req,
        e_wait,
        e_write,
        e_fault
    } bp_ptw_state_e;

    typedef struct packed {
        logic [9:0]               reserved;
        logic [ptag_width_gp-1:0] ppn;
        logic [1:0]               rsw;
        logic                     d;
        logic                     a;
        logic                     g;
        logic                     u;
        logic                     x;
        logic                     w;
        logic                     r;
        logic                     v;
    } bp_sv39_pte_s;

    typedef struct packed {
        logic [ptag_width_gp-1:0] ptag;
        logic                     d;
        logic                     a;
        logic                     u;
        logic                     x;
        logic                     w;
        logic                     r;
    } bp_pte_entry_leaf_s;

    function automatic int bp_pte_entry_leaf_width(input int paddr_width);
        return paddr_width - 12 + 6;
    endfunction

    localparam int entry_width_gp = bp_pte_entry_leaf_width(paddr_width_gp);

    // Low 9*level bits set: the PPN bits a superpage at this level maps
    // straight through from the virtual address.
    function automatic logic [ptag_width_gp-1:0] sv39_level_mask(
        input logic [sv39_level_width_gp-1:0] level
    );
        logic [ptag_width_gp-1:0] mask;
        mask = '0;
        for (int i = 0; i < (sv39_levels_gp - 1) * sv39_vpn_width_gp; i++) begin
            if (i < sv39_vpn_width_gp * int'(level)) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bp_ptw.sv
// ----------------------------------------------------------------------------
// bp_ptw
//   Sv39 hardware page-table walker. Accepts a TLB miss while idle, issues one
//   PTE load per level, and ends with either a one-cycle TLB fill strobe or a
//   one-cycle page-fault pulse.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   flush_i                 abort the walk; no fill or fault results
//   base_ppn_i              root page-table PPN, sampled when a walk starts
//   miss_v_i, miss_vtag_i   TLB miss (only accepted when idle)
//   busy_o                  walk in progress
//   mem_v_o, mem_addr_o     PTE load request (held until mem_ready_i)
//   mem_ready_i             request accepted
//   mem_data_v_i, mem_data_i PTE response (ignored outside e_wait)
//   tlb_w_v_o/_vtag_o/_entry_o   TLB fill strobe, vtag and leaf entry
//   page_fault_v_o/_vtag_o       fault pulse and faulting vtag
// ----------------------------------------------------------------------------
module bp_ptw
    import bp_common_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic [ptag_width_gp-1:0]  base_ppn_i,
    input  logic                      miss_v_i,
    input  logic [vtag_width_gp-1:0]  miss_vtag_i,
    output logic                      busy_o,
    output logic                      mem_v_o,
    output logic [paddr_width_gp-1:0] mem_addr_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_data_v_i,
    input  logic [63:0]               mem_data_i,
    output logic                      tlb_w_v_o,
    output logic [vtag_width_gp-1:0]  tlb_w_vtag_o,
    output logic [entry_width_gp-1:0] tlb_w_entry_o,
    output logic                      page_fault_v_o,
    output logic [vtag_width_gp-1:0]  page_fault_vtag_o
);

    bp_ptw_state_e                  state_r, state_n;
    logic [vtag_width_gp-1:0]       vtag_r;
    logic [ptag_width_gp-1:0]       cur_ppn_r;
    logic [sv39_level_width_gp-1:0] level_r;
    logic                           abort_r;
    bp_pte_entry_leaf_s             leaf_r;
    bp_pte_entry_leaf_s             fill_entry;

    bp_sv39_pte_s                   pte;
    logic                           start, descend;
    logic                           pte_bad, pte_leaf, pte_misaligned;
    logic [ptag_width_gp-1:0]       level_mask, vtag_ext;
    logic [sv39_vpn_width_gp-1:0]   vpn;

    assign pte            = mem_data_i;
    assign level_mask     = sv39_level_mask(level_r);
    assign pte_leaf       = pte.r | pte.x;
    assign pte_bad        = ~pte.v | (~pte.r & pte.w);
    assign pte_misaligned = |(pte.ppn & level_mask);

    // Reserved, RSW and G bits play no part in the walk.
    logic unused_pte_bits;
    assign unused_pte_bits = ^{pte.reserved, pte.rsw, pte.g};

    always_comb begin
        case (level_r)
            2'd2:    vpn = vtag_r[26:18];
            2'd1:    vpn = vtag_r[17:9];
            default: vpn = vtag_r[8:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_n = state_r;
        start   = 1'b0;
        descend = 1'b0;
        unique case (state_r)
            e_idle: begin
                if (miss_v_i && !flush_i) begin
                    start   = 1'b1;
                    state_n = e_req;
                end
            end
            e_req: begin
                if (flush_i)          state_n = e_idle;
                else if (mem_ready_i) state_n = e_wait;
            end
            e_wait: begin
                // A flushed walk still waits for its response so the memory
                // never sees a second request while one is outstanding.
                if (mem_data_v_i) begin
                    if (abort_r || flush_i) state_n = e_idle;
                    else if (pte_bad)       state_n = e_fault;
                    else if (pte_leaf)      state_n = pte_misaligned ? e_fault : e_write;
                    else if (level_r == '0) state_n = e_fault;
                    else begin
                        descend = 1'b1;
                        state_n = e_req;
                    end
                end
            end
            e_write, e_fault: state_n = e_idle;
            default:          state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vtag_r    <= '0;
            cur_ppn_r <= '0;
            level_r   <= 2'd2;
            abort_r   <= 1'b0;
            leaf_r    <= '0;
        end else begin
            if (start) begin
                vtag_r    <= miss_vtag_i;
                cur_ppn_r <= base_ppn_i;
                level_r   <= 2'd2;
            end else if (descend) begin
                cur_ppn_r <= pte.ppn;
                level_r   <= level_r - 2'd1;
            end
            // Captured on every response; only consumed when the walk ends in e_write.
            if (state_r == e_wait && mem_data_v_i) begin
                leaf_r <= '{ptag: pte.ppn, d: pte.d, a: pte.a, u: pte.u,
                            x: pte.x, w: pte.w, r: pte.r};
            end
            abort_r <= (state_r == e_wait) && !mem_data_v_i && (abort_r || flush_i);
        end
    end

    // Superpage splice: PPN bits below the leaf level come from the vtag.
    assign vtag_ext = {{(ptag_width_gp - vtag_width_gp){1'b0}}, vtag_r};

    always_comb begin
        fill_entry      = leaf_r;
        fill_entry.ptag = (leaf_r.ptag & ~level_mask) | (vtag_ext & level_mask);
    end

    assign busy_o            = (state_r != e_idle);
    assign mem_v_o           = (state_r == e_req);
    assign mem_addr_o        = {cur_ppn_r, vpn, {sv39_pte_offset_width_gp{1'b0}}};
    assign tlb_w_v_o         = (state_r == e_write) && !flush_i && !reset_i;
    assign tlb_w_vtag_o      = vtag_r;
    assign tlb_w_entry_o     = fill_entry;
    assign page_fault_v_o    = (state_r == e_fault) && !flush_i && !reset_i;
    assign page_fault_vtag_o = vtag_r;

endmodule

// File: tb/tb_bp_ptw.sv
// ----------------------------------------------------------------------------
// tb_bp_ptw
//   Directed testbench for bp_ptw. Inputs change and outputs are sampled on
//   the falling clock edge; "cycle N" comments count from the cycle in which
//   miss_v_i is presented.
// ----------------------------------------------------------------------------
module tb_bp_ptw;
    import bp_common_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset_i;
    logic                      flush_i;
    logic [ptag_width_gp-1:0]  base_ppn_i;
    logic                      miss_v_i;
    logic [vtag_width_gp-1:0]  miss_vtag_i;
    logic                      busy_o;
    logic                      mem_v_o;
    logic [paddr_width_gp-1:0] mem_addr_o;
    logic                      mem_ready_i;
    logic                      mem_data_v_i;
    logic [63:0]               mem_data_i;
    logic                      tlb_w_v_o;
    logic [vtag_width_gp-1:0]  tlb_w_vtag_o;
    logic [entry_width_gp-1:0] tlb_w_entry_o;
    logic                      page_fault_v_o;
    logic [vtag_width_gp-1:0]  page_fault_vtag_o;

    logic [3:0] st;
    assign st = {busy_o, mem_v_o, tlb_w_v_o, page_fault_v_o};

    int checks = 0;
    int errors = 0;

    bp_ptw dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .base_ppn_i       (base_ppn_i),
        .miss_v_i         (miss_v_i),
        .miss_vtag_i      (miss_vtag_i),
        .busy_o           (busy_o),
        .mem_v_o          (mem_v_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_data_v_i     (mem_data_v_i),
        .mem_data_i       (mem_data_i),
        .tlb_w_v_o        (tlb_w_v_o),
        .tlb_w_vtag_o     (tlb_w_vtag_o),
        .tlb_w_entry_o    (tlb_w_entry_o),
        .page_fault_v_o   (page_fault_v_o),
        .page_fault_vtag_o(page_fault_vtag_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'b0, ppn, 2'b0, flags};
    endfunction

    // Presents a miss for one cycle (cycle 0) and moves to cycle 1.
    task automatic issue_miss(input logic [26:0] vtag);
        miss_v_i    = 1'b1;
        miss_vtag_i = vtag;
        base_ppn_i  = 44'h80000;
        step();
        miss_v_i    = 1'b0;
    endtask

    // Drives a one-cycle PTE response in the current cycle, moves to the next.
    task automatic respond(input logic [63:0] pte);
        mem_data_v_i = 1'b1;
        mem_data_i   = pte;
        step();
        mem_data_v_i = 1'b0;
        mem_data_i   = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) step();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp %b", st, 4'b0000); end
        checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
        checks++; if (tlb_w_entry_o !== '0 || tlb_w_vtag_o !== '0 || page_fault_vtag_o !== '0) begin
            errors++; $display("FAIL reset_data got entry %h vtag %h fvtag %h exp 0", tlb_w_entry_o, tlb_w_vtag_o, page_fault_vtag_o);
        end
        reset_i = 1'b0;
        step();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_release got %b exp %b", st, 4'b0000); end
    endtask

    task automatic test_three_level();
        issue_miss(27'h0012345);                     // cycle 1
        base_ppn_i = 44'h12345;                      // must not affect the walk
        checks++; if (st !== 4'b1100 || mem_addr_o !== 56'h80000000) begin
            errors++; $display("FAIL l3_req2 got %b/%h exp 1100/80000000", st, mem_addr_o);
        end
        step();                                      // cycle 2
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL l3_wait2 got %b exp 1000", st); end
        respond(mk_pte(44'h80001, 8'h01));           // cycle 3
        checks++; if (st !== 4'b1100 || mem_addr_o !== 56'h80001488) begin
            errors++; $display("FAIL l3_req1 got %b/%h exp 1100/80001488", st, mem_addr_o);
        end
        step();                                      // cycle 4
        respond(mk_pte(44'h80002, 8'h01));           // cycle 5
        checks++; if (st !== 4'b1100 || mem_addr_o !== 56'h80002a28) begin
            errors++; $display("FAIL l3_req0 got %b/%h exp 1100/80002a28", st, mem_addr_o);
        end
        step();                                      // cycle 6
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL l3_wait0 got %b exp 1000", st); end
        respond(mk_pte(44'h80123, 8'hc7));           // cycle 7
        checks++; if (st !== 4'b1010) begin errors++; $display("FAIL l3_fill_flags got %b exp 1010", st); end
        checks++; if (tlb_w_entry_o !== {44'h80123, 6'b110011} || tlb_w_vtag_o !== 27'h0012345) begin
            errors++; $display("FAIL l3_fill_entry got %h/%h exp %h/0012345", tlb_w_entry_o, tlb_w_vtag_o, {44'h80123, 6'b110011});
        end
        step();                                      // cycle 8
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL l3_idle got %b exp 0000", st); end
        base_ppn_i = 44'h80000;
    endtask

    task automatic test_superpage();
        logic [43:0] ppn;
        for (int k = 0; k < 2; k++) begin
            ppn = (k == 0) ? 44'h80200 : 44'h80201;
            issue_miss(27'h0040445);                 // cycle 1
            checks++; if (mem_addr_o !== 56'h80000008) begin errors++; $display("FAIL sp%0d_req2 got %h exp 80000008", k, mem_addr_o); end
            step();
            respond(mk_pte(44'h80100, 8'h01));       // cycle 3
            checks++; if (mem_addr_o !== 56'h80100010) begin errors++; $display("FAIL sp%0d_req1 got %h exp 80100010", k, mem_addr_o); end
            step();
            respond(mk_pte(ppn, 8'h4b));             // cycle 5
            if (k == 0) begin
                checks++; if (st !== 4'b1010 || tlb_w_entry_o !== {44'h80245, 6'b010101}) begin
                    errors++; $display("FAIL sp_aligned got %b/%h exp 1010/%h", st, tlb_w_entry_o, {44'h80245, 6'b010101});
                end
            end else begin
                checks++; if (st !== 4'b1001 || page_fault_vtag_o !== 27'h0040445) begin
                    errors++; $display("FAIL sp_misaligned got %b/%h exp 1001/0040445", st, page_fault_vtag_o);
                end
            end
            step();                                  // cycle 6
            checks++; if (st !== 4'b0000) begin errors++; $display("FAIL sp%0d_idle got %b exp 0000", k, st); end
        end
    endtask

    task automatic test_invalid_pte();
        issue_miss(27'h7654321);                     // cycle 1
        checks++; if (mem_addr_o !== 56'h80000ec8) begin errors++; $display("FAIL inv_req got %h exp 80000ec8", mem_addr_o); end
        step();
        respond(mk_pte(44'h80000, 8'hc6));           // cycle 3: V=0
        checks++; if (st !== 4'b1001 || page_fault_vtag_o !== 27'h7654321) begin
            errors++; $display("FAIL inv_fault got %b/%h exp 1001/7654321", st, page_fault_vtag_o);
        end
        step();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL inv_idle got %b exp 0000", st); end
    endtask

    task automatic test_ready_stall();
        mem_ready_i = 1'b0;
        issue_miss(27'h00c1234);                     // cycle 1
        for (int c = 1; c <= 5; c++) begin
            checks++; if (st !== 4'b1100 || mem_addr_o !== 56'h80000018) begin
                errors++; $display("FAIL stall_c%0d got %b/%h exp 1100/80000018", c, st, mem_addr_o);
            end
            if (c == 5) mem_ready_i = 1'b1;
            step();
        end
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL stall_wait got %b exp 1000", st); end
        respond(mk_pte(44'h80000, 8'hdf));           // cycle 7
        checks++; if (st !== 4'b1010 || tlb_w_entry_o !== {44'h81234, 6'b111111}) begin
            errors++; $display("FAIL stall_fill got %b/%h exp 1010/%h", st, tlb_w_entry_o, {44'h81234, 6'b111111});
        end
        step();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL stall_idle got %b exp 0000", st); end
    endtask

    task automatic test_flush_wait();
        issue_miss(27'h0000007);                     // cycle 1
        step();                                      // cycle 2: e_wait
        flush_i = 1'b1;
        step();                                      // cycle 3
        flush_i = 1'b0;
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL flush_hold got %b exp 1000", st); end
        step();                                      // cycle 4
        respond(mk_pte(44'h80000, 8'hc7));           // cycle 5
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL flush_done got %b exp 0000", st); end
        step();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL flush_late got %b exp 0000", st); end
    endtask

    task automatic test_back_to_back();
        issue_miss(27'h0000011);                     // cycle 1
        miss_v_i    = 1'b1;                          // dropped: walk busy
        miss_vtag_i = 27'h0140022;
        step();                                      // cycle 2
        miss_v_i = 1'b0;
        respond(mk_pte(44'h80000, 8'hc7));           // cycle 3
        checks++; if (st !== 4'b1010 || tlb_w_vtag_o !== 27'h0000011 || tlb_w_entry_o !== {44'h80011, 6'b110011}) begin
            errors++; $display("FAIL b2b_first got %b/%h/%h exp 1010/0000011/%h", st, tlb_w_vtag_o, tlb_w_entry_o, {44'h80011, 6'b110011});
        end
        step();                                      // cycle 4: idle
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL b2b_gap got %b exp 0000", st); end
        issue_miss(27'h0140022);
        checks++; if (st !== 4'b1100 || mem_addr_o !== 56'h80000028) begin
            errors++; $display("FAIL b2b_req got %b/%h exp 1100/80000028", st, mem_addr_o);
        end
        step();
        respond(mk_pte(44'h80000, 8'hc7));
        checks++; if (st !== 4'b1010 || tlb_w_vtag_o !== 27'h0140022 || tlb_w_entry_o !== {44'h80022, 6'b110011}) begin
            errors++; $display("FAIL b2b_second got %b/%h/%h exp 1010/0140022/%h", st, tlb_w_vtag_o, tlb_w_entry_o, {44'h80022, 6'b110011});
        end
        step();
    endtask

    task automatic test_abort_pulses();
        // reset in e_write: pulse suppressed at once
        issue_miss(27'h0000003);
        step();
        respond(mk_pte(44'h80000, 8'hc7));           // cycle 3: e_write
        reset_i = 1'b1;
        #1;
        checks++; if (tlb_w_v_o !== 1'b0) begin errors++; $display("FAIL rst_write_pulse got %b exp 0", tlb_w_v_o); end
        step();
        reset_i = 1'b0;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL rst_write_idle got %b exp 0000", st); end
        // flush in e_fault: pulse suppressed
        issue_miss(27'h0000004);
        step();
        respond(64'h0);                              // cycle 3: e_fault
        flush_i = 1'b1;
        #1;
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL flush_fault got %b exp 1000", st); end
        step();
        flush_i = 1'b0;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL flush_fault_idle got %b exp 0000", st); end
        // reset mid-walk in e_wait, then a stray response is ignored
        issue_miss(27'h0000005);
        step();                                      // cycle 2: e_wait
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL rst_wait got %b exp 0000", st); end
        respond(mk_pte(44'h80000, 8'hc7));
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL stray_resp got %b exp 0000", st); end
    endtask

    initial begin
        reset_i      = 1'b1;
        flush_i      = 1'b0;
        base_ppn_i   = 44'h80000;
        miss_v_i     = 1'b0;
        miss_vtag_i  = '0;
        mem_ready_i  = 1'b1;
        mem_data_v_i = 1'b0;
        mem_data_i   = '0;
        step();
        test_reset();
        test_three_level();
        test_superpage();
        test_invalid_pte();
        test_ready_stall();
        test_flush_wait();
        test_back_to_back();
        test_abort_pulses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
